// File: rtl/lsu.sv
// Load/store unit: one outstanding access on a valid/ready data-memory port, aligned/extended load writeback.
// Optional LSU_MISALIGN_TRAP_EN: misaligned accesses fault instead of being forced aligned.
module lsu #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [RD_W-1:0] req_rd,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            resp_valid,
  output logic [RD_W-1:0] resp_rd,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_err,
  output logic [1:0]      dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // the offering side holds valid and its payload stable until that edge.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MEM = 2'd1, S_RESP = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [2:0]        f3_q, f3_d;
  logic              store_q, store_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              err_q, err_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;

  logic              legal, misal, fault;
  logic [3:0]        strb;
  logic [XLEN-1:0]   wlane;
  logic [XLEN-1:0]   byte_sh, half_sh, ext;

  always_comb begin
    legal = req_store ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                      : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
            ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_TRAP_EN
    fault = !legal || misal;
`else
    fault = !legal;
`endif
    // Halfword lanes come from addr[1] only, so an odd address is forced aligned.
    case (req_funct3[1:0])
      2'b00: begin
        strb  = 4'b0001 << req_addr[1:0];
        wlane = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        strb  = 4'b0011 << {req_addr[1], 1'b0};
        wlane = {2{req_wdata[15:0]}};
      end
      default: begin
        strb  = 4'b1111;
        wlane = req_wdata;
      end
    endcase
  end

  always_comb begin
    byte_sh = mem_rdata >> {addr_q[1:0], 3'b000};
    half_sh = mem_rdata >> {addr_q[1], 4'b0000};
    case (f3_q)
      3'b000:  ext = {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'b001:  ext = {{16{half_sh[15]}}, half_sh[15:0]};
      3'b100:  ext = {24'd0, byte_sh[7:0]};
      3'b101:  ext = {16'd0, half_sh[15:0]};
      default: ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    store_d = store_q;
    rd_d    = rd_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          f3_d    = req_funct3;
          store_d = req_store;
          rd_d    = (req_store || fault) ? '0 : req_rd;
          wdata_d = req_store ? wlane : '0;
          wstrb_d = req_store ? strb : 4'b0000;
          err_d   = fault;
          rdata_d = '0;
          state_d = fault ? S_RESP : S_MEM;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          rdata_d = store_q ? '0 : ext;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      store_q <= 1'b0;
      rd_q    <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      store_q <= store_d;
      rd_q    <= rd_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs are gated by rst_n so everything reads 0 while reset is held, even mid-access.
  assign req_ready  = rst_n && (state_q == S_IDLE);
  assign mem_valid  = rst_n && (state_q == S_MEM);
  assign mem_we     = mem_valid && store_q;
  assign mem_addr   = mem_valid ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign mem_wstrb  = mem_valid ? wstrb_q : 4'b0000;
  assign mem_wdata  = mem_valid ? wdata_q : '0;
  assign resp_valid = rst_n && (state_q == S_RESP);
  assign resp_rd    = resp_valid ? rd_q : '0;
  assign resp_data  = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid && err_q;
  assign dbg_state  = rst_n ? state_q : S_IDLE;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases then randomized accesses against a byte-lane reference model.
module tb_lsu;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_valid, mem_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        resp_valid, resp_err;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  lsu dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_data(resp_data), .resp_err(resp_err),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    bit          we;
    logic [31:0] maddr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] data;
    logic [4:0]  rd;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: access size in bytes, lane offset rounded down to the size, byte-lane arithmetic.
  function automatic exp_t model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] rdat, input logic [4:0] rd);
    exp_t e;
    int size, off;
    bit legal;
    logic [31:0] mask, v;
    legal   = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size    = 1 << f3[1:0];
    e.err   = !legal || (TRAP && (int'(a[1:0]) % size) != 0);
    off     = (int'(a[1:0]) / size) * size;
    e.maddr = a & ~32'h3;
    e.we    = st;
    e.strb  = st ? 4'(((1 << size) - 1) << off) : 4'b0000;
    for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wd[8*(i % size) +: 8];
    mask = (size >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);
    v    = (rdat >> (8*off)) & mask;
    if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
    e.data = (st || e.err) ? 32'd0 : v;
    e.rd   = (st || e.err) ? 5'd0 : rd;
    return e;
  endfunction

  // Enters and leaves at a negedge with the unit idle.
  task automatic run_access(input string nm, input bit st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rdat, input logic [4:0] rd,
                            input int waits);
    exp_t e;
    e = model(st, f3, a, wd, rdat, rd);
    chk({nm, ".req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
    @(negedge clk);
    req_valid = 1'b0; req_store = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
    if (!e.err) begin
      for (int w = 0; w <= waits; w++) begin
        chk({nm, ".mem_valid"}, 32'(mem_valid), 32'd1);
        chk({nm, ".mem_we"}, 32'(mem_we), 32'(e.we));
        chk({nm, ".mem_addr"}, mem_addr, e.maddr);
        chk({nm, ".mem_wstrb"}, 32'(mem_wstrb), 32'(e.strb));
        if (st) chk({nm, ".mem_wdata"}, mem_wdata, e.wdata);
        chk({nm, ".req_ready_busy"}, 32'(req_ready), 32'd0);
        chk({nm, ".resp_early"}, 32'(resp_valid), 32'd0);
        mem_ready = (w == waits);
        mem_rdata = (w == waits) ? rdat : $urandom;
        @(negedge clk);
      end
      mem_ready = 1'b0;
      mem_rdata = $urandom;
    end
    chk({nm, ".resp_valid"}, 32'(resp_valid), 32'd1);
    chk({nm, ".resp_err"}, 32'(resp_err), 32'(e.err));
    chk({nm, ".resp_data"}, resp_data, e.data);
    chk({nm, ".resp_rd"}, 32'(resp_rd), 32'(e.rd));
    chk({nm, ".mem_valid_resp"}, 32'(mem_valid), 32'd0);
    chk({nm, ".req_ready_resp"}, 32'(req_ready), 32'd0);
    @(negedge clk);
    chk({nm, ".resp_pulse"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = '0; req_rd = '0; mem_ready = 1'b0; mem_rdata = '0;

    repeat (3) @(negedge clk);
    chk("rst.req_ready", 32'(req_ready), 32'd0);
    chk("rst.mem_valid", 32'(mem_valid), 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    chk("rst.mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.resp_data", resp_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_access("lw", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 5'd3, 0);
    chk("lw.literal_model", model(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 5'd3).data, 32'hDEADBEEF);
    run_access("lb", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 5'd4, 0);
    run_access("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456, 5'd5, 1);
    run_access("lhu", 1'b0, 3'b101, 32'h102, 32'h0, 32'h80123456, 5'd6, 0);
    run_access("lh", 1'b0, 3'b001, 32'h102, 32'h0, 32'h80123456, 5'd7, 2);
    run_access("sb", 1'b1, 3'b000, 32'h201, 32'h000000AB, 32'h0, 5'd9, 0);
    run_access("sh", 1'b1, 3'b001, 32'h0, 32'h1234CAFE, 32'h0, 5'd10, 3);
    run_access("sw", 1'b1, 3'b010, 32'h30C, 32'h01020304, 32'h0, 5'd11, 1);
    run_access("lw_mis", 1'b0, 3'b010, 32'h102, 32'h0, 32'h55AA33CC, 5'd12, 0);
    run_access("lh_odd", 1'b0, 3'b001, 32'h103, 32'h0, 32'hF00F1234, 5'd13, 0);
    run_access("ill_ld", 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 5'd14, 0);
    run_access("ill_st", 1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 5'd15, 0);

    // Reset while the access waits in MEM: the request is withdrawn and never answered.
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h440; req_rd = 5'd1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstmem.mem_valid_before", 32'(mem_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmem.mem_valid_in_reset", 32'(mem_valid), 32'd0);
    @(negedge clk);
    chk("rstmem.mem_valid_after", 32'(mem_valid), 32'd0);
    chk("rstmem.resp_valid_after", 32'(resp_valid), 32'd0);
    chk("rstmem.dbg_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("rstmem.req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("rstmem.no_resp", 32'(resp_valid), 32'd0);
      chk("rstmem.no_mem", 32'(mem_valid), 32'd0);
      @(negedge clk);
    end
    mem_ready = 1'b0;

    for (int n = 0; n < 60; n++) begin
      run_access("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                 $urandom, $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
